// File: rtl/fifo_umbral.sv
// fifo_umbral: synchronous FIFO with programmable low/high watermark flags.
// Per-queue buffer whose flags feed the transaction-layer control FSM.
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous active-low reset
//   push/pop     write/read requests
//   data_in      write data
//   umbral_bajo  low threshold  (almost_empty when count <= umbral_bajo)
//   umbral_alto  high threshold (almost_full  when count >= umbral_alto)
//   data_out     registered read data, valid one cycle after an accepted pop
//   valid_out    data_out holds the word popped in the previous cycle
//   empty/full   count == 0 / count == DEPTH
//   error        sticky overflow/underflow, cleared only by reset
//   count        current fill level 0..DEPTH
module fifo_umbral #(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [2:0]            umbral_bajo,
  input  logic [2:0]            umbral_alto,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  pop_ok, push_ok, ovf, unf;
  logic [ADDR_WIDTH:0]   bajo_ext, alto_ext;

  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign ovf     = push && !push_ok;
  assign unf     = pop && empty;

  assign empty    = (count == '0);
  assign full     = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign bajo_ext = (ADDR_WIDTH+1)'(umbral_bajo);
  assign alto_ext = (ADDR_WIDTH+1)'(umbral_alto);
  assign almost_empty = (count <= bajo_ext);
  assign almost_full  = (count >= alto_ext);

  // Storage is not reset; only gated so nothing is written in a reset cycle.
  always_ff @(posedge clk) begin
    if (reset && push_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      valid_out <= pop_ok;
      if (pop_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf || unf) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_umbral.sv
// Self-checking bench for fifo_umbral: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_fifo_umbral;
  logic       clk = 1'b0;
  logic       reset, push, pop;
  logic [5:0] data_in, data_out;
  logic [2:0] umbral_bajo, umbral_alto;
  logic       valid_out, empty, full, almost_empty, almost_full, error;
  logic [3:0] count;

  int n_chk = 0;
  int n_fail = 0;

  logic [5:0] mq[$];
  logic [5:0] m_dout;
  bit         m_vld, m_err;

  fifo_umbral #(.DATA_WIDTH(6), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .umbral_bajo(umbral_bajo), .umbral_alto(umbral_alto),
    .data_out(data_out), .valid_out(valid_out), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .error(error),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    chk("count", count, n);
    chk("empty", empty, n == 0);
    chk("full", full, n == 8);
    chk("almost_empty", almost_empty, n <= int'(umbral_bajo));
    chk("almost_full", almost_full, n >= int'(umbral_alto));
    chk("valid_out", valid_out, m_vld);
    chk("error", error, m_err);
    chk("data_out", data_out, m_dout);
  endtask

  // Inputs driven at the falling edge, model stepped at the rising edge,
  // outputs checked at the following falling edge.
  task automatic cyc(input bit rs_n, input bit ps, input bit pp, input logic [5:0] d);
    bit pop_ok, push_ok;
    reset = rs_n; push = ps; pop = pp; data_in = d;
    @(posedge clk);
    if (!rs_n) begin
      mq.delete(); m_dout = '0; m_vld = 0; m_err = 0;
    end else begin
      pop_ok  = pp && (mq.size() > 0);
      push_ok = ps && ((mq.size() < 8) || pop_ok);
      if (pp && mq.size() == 0) m_err = 1;
      if (ps && !push_ok)       m_err = 1;
      m_vld = pop_ok;
      if (pop_ok)  m_dout = mq.pop_front();
      if (push_ok) mq.push_back(d);
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    umbral_bajo = 3'd1; umbral_alto = 3'd7;
    m_dout = '0; m_vld = 0; m_err = 0;

    // Reset and empty state
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_error", error, 0);

    // Fill to full
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 1, 0, 6'(i));
      chk("fill_count", count, i);
    end
    chk("fill_full", full, 1);
    chk("fill_error", error, 0);

    // Drain in order, then one underflow
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 1, 0);
      chk("drain_data", data_out, i);
      chk("drain_vld", valid_out, 1);
    end
    chk("drain_empty", empty, 1);
    cyc(1, 0, 1, 0);
    chk("unf_vld", valid_out, 0);
    chk("unf_error", error, 1);

    // Overflow and pointer wrap
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 6'(8'h10 + i));
    cyc(1, 1, 0, 6'h3F);
    chk("ovf_count", count, 8);
    chk("ovf_error", error, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 1, 0);
      chk("ovf_drain", data_out, 8'h10 + i);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 0, 6'(8'h20 + i));
      cyc(1, 0, 1, 0);
      chk("wrap_data", data_out, 8'h20 + i);
    end

    // Simultaneous push+pop at full and at empty
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 6'(i + 1));
    cyc(1, 1, 1, 6'h2A);
    chk("pp_full_count", count, 8);
    chk("pp_full_error", error, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 1, 0);
    chk("pp_full_last", data_out, 8'h2A);
    cyc(1, 1, 1, 6'h15);
    chk("pp_empty_count", count, 1);
    chk("pp_empty_vld", valid_out, 0);
    chk("pp_empty_error", error, 1);

    // Mid-operation reset with a push pending, then threshold edge
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 6'(i));
    chk("mid_count_pre", count, 5);
    cyc(0, 1, 1, 6'h33);
    chk("mid_count", count, 0);
    chk("mid_empty", empty, 1);
    chk("mid_error", error, 0);
    umbral_alto = 3'd0;
    #1;
    chk("alto0_af", almost_full, 1);
    umbral_bajo = 3'd7;
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 6'(i));
    chk("cnt8_ae", almost_empty, 0);
    chk("cnt8_af", almost_full, 1);

    // Random traffic with changing thresholds and occasional resets
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        umbral_bajo = 3'($urandom_range(0, 7));
        umbral_alto = 3'($urandom_range(0, 7));
        #1;
        check_all();
      end
      cyc($urandom_range(0, 99) != 0, 1'($urandom), 1'($urandom), 6'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
